// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - requester, response and AES core bus bundle for aes_core_arbiter
// master = client/core side, slave = arbiter side.
interface aes_core_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ*256-1:0] req_key;
  logic [NUM_REQ-1:0]     req_ack;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_data;
  logic                   resp_err;

  logic                   core_start;
  logic [127:0]           core_data_in;
  logic [255:0]           core_key;
  logic [127:0]           core_data_out;
  logic                   core_valid;

  modport master (
    output req_valid, req_data, req_key, resp_ready, core_data_out, core_valid,
    input  req_ack, resp_valid, resp_id, resp_data, resp_err,
    input  core_start, core_data_in, core_key
  );

  modport slave (
    input  req_valid, req_data, req_key, resp_ready, core_data_out, core_valid,
    output req_ack, resp_valid, resp_id, resp_data, resp_err,
    output core_start, core_data_in, core_key
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin sharing of one AES core between NUM_REQ requesters
// One request in flight at a time; a timed-out request returns resp_err with zero data.
module aes_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  aes_core_arbiter_if.slave bus,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_req_ack;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [127:0]       r_resp_data;
  logic               r_resp_err;
  logic               r_core_start;
  logic [127:0]       r_core_data_in;
  logic [255:0]       r_core_key;
  logic               r_busy;

  logic [2*NUM_REQ-1:0] w_dbl_valid;
  logic [NUM_REQ-1:0]   w_rot_valid;
  logic [ID_W:0]        w_shamt;
  logic                 w_any;
  int                   w_offset;
  logic [ID_W-1:0]      w_win;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [127:0]         w_win_data;
  logic [255:0]         w_win_key;

  // Rotating a doubled copy puts requester rr_last+1 at bit 0, so the lowest set bit is the winner.
  assign w_dbl_valid = {bus.req_valid, bus.req_valid};
  assign w_shamt     = {1'b0, r_rr_last} + (ID_W+1)'(1);
  assign w_rot_valid = NUM_REQ'(w_dbl_valid >> w_shamt);
  assign w_any       = |bus.req_valid;

  always_comb begin
    w_offset     = 0;
    w_win_onehot = '0;
    w_win_data   = '0;
    w_win_key    = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot_valid[j]) begin
        w_offset = j;
      end
    end
    w_win = ID_W'((int'(r_rr_last) + 1 + w_offset) % NUM_REQ);
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == ID_W'(j)) begin
        w_win_onehot[j] = 1'b1;
        w_win_data      = bus.req_data[j*128 +: 128];
        w_win_key       = bus.req_key[j*256 +: 256];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rr_last      <= ID_W'(NUM_REQ - 1);
      r_cnt          <= '0;
      r_req_ack      <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_data    <= '0;
      r_resp_err     <= 1'b0;
      r_core_start   <= 1'b0;
      r_core_data_in <= '0;
      r_core_key     <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_req_ack    <= '0;
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_core_data_in <= w_win_data;
            r_core_key     <= w_win_key;
            r_resp_id      <= w_win;
            r_req_ack      <= w_win_onehot;
            r_busy         <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_core_start <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A result arriving on the last permitted cycle still counts as success.
          if (bus.core_valid) begin
            r_resp_data  <= bus.core_data_out;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rr_last    <= r_resp_id;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ack      = r_req_ack;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_err     = r_resp_err;
  assign bus.core_start   = r_core_start;
  assign bus.core_data_in = r_core_data_in;
  assign bus.core_key     = r_core_key;
  assign o_busy           = r_busy;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - randomized self-checking bench for aes_core_arbiter
// A latency-programmable fake AES core and a round-robin reference model live here.
module tb_aes_core_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  logic [127:0] rd [NUM_REQ];
  logic [255:0] rk [NUM_REQ];
  int           m_rr       = NUM_REQ - 1;
  int           core_lat   = 0;
  bit           force_dead = 1'b0;
  bit           core_pending = 1'b0;
  int           core_cd    = 0;

  aes_core_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  aes_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc(input logic [127:0] d, input logic [255:0] k);
    return d ^ k[127:0] ^ {k[191:128], k[255:192]} ^ 128'hC3A5_5A3C_0F1E_2D3C_4B5A_6978_8796_A5B4;
  endfunction

  // Next grant: first pending requester after the last one served, wrapping around.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Fake core: a new start restarts it; the result pulses core_lat cycles later (0 = never).
  always @(negedge clk) begin
    bus.core_valid = 1'b0;
    if (bus.core_start === 1'b1) begin
      core_pending = (core_lat > 0);
      core_cd      = core_lat - 1;
      bus.core_data_out = force_dead ? 128'hDEAD : enc(bus.core_data_in, bus.core_key);
    end
    if (core_pending) begin
      if (core_cd == 0) begin
        bus.core_valid = 1'b1;
        core_pending   = 1'b0;
      end else begin
        core_cd--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data[i*128 +: 128] = rd[i];
      bus.req_key[i*256 +: 256]  = rk[i];
    end
    bus.req_valid = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_rr  = NUM_REQ - 1;
  endtask

  task automatic wait_ack(input int limit, output int cyc, output logic [NUM_REQ-1:0] ack);
    cyc = 0;
    ack = '0;
    while (cyc < limit) begin
      tick();
      cyc++;
      if (bus.req_ack !== '0) begin
        ack = bus.req_ack;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      tick();
      cyc++;
      if (bus.resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cyc; bit ok; logic [NUM_REQ-1:0] ack;
    reset = 1'b1;
    bus.req_data = '0;
    bus.req_key  = '0;
    bus.resp_ready = 1'b0;
    bus.req_valid  = '1;
    tick();
    tick();
    total++;
    if (bus.req_ack !== '0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ack=%b rv=%b err=%b want all 0", bus.req_ack, bus.resp_valid, bus.resp_err);
    end
    total++;
    if (bus.resp_id !== '0 || bus.resp_data !== '0) begin
      bad++;
      $display("FAIL reset_resp: got id=%0d data=%h want 0", bus.resp_id, bus.resp_data);
    end
    total++;
    if (bus.core_start !== 1'b0 || bus.core_data_in !== '0 || bus.core_key !== '0) begin
      bad++;
      $display("FAIL reset_core: got start=%b din=%h key=%h want 0", bus.core_start, bus.core_data_in, bus.core_key);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    // Both requesters pending when reset drops: requester 0 must win.
    core_lat = 3;
    reset = 1'b0;
    m_rr  = NUM_REQ - 1;
    wait_ack(4, cyc, ack);
    total++;
    if (ack !== NUM_REQ'(1 << pick(2'b11, m_rr))) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want %b", ack, NUM_REQ'(1 << pick(2'b11, m_rr)));
    end
    bus.req_valid = '0;
    wait_resp(20, cyc, ok);
    accept_resp();
    m_rr = 0;
  endtask

  task automatic test_single();
    int cyc; bit ok; logic [NUM_REQ-1:0] ack;
    do_reset();
    core_lat   = 14;
    force_dead = 1'b1;
    rd[0] = 128'd1;
    rk[0] = 256'd1;
    rd[1] = '0;
    rk[1] = '0;
    drive_reqs(2'b01);
    wait_ack(5, cyc, ack);
    total++;
    if (ack !== 2'b01 || cyc != 1) begin
      bad++;
      $display("FAIL single_ack: got ack=%b after %0d cycles want 01 after 1", ack, cyc);
    end
    bus.req_valid = '0;
    tick();
    total++;
    if (bus.core_start !== 1'b1 || bus.core_data_in !== 128'd1 || bus.core_key !== 256'd1) begin
      bad++;
      $display("FAIL single_start: got start=%b din=%h key=%h want 1,1,1", bus.core_start, bus.core_data_in, bus.core_key);
    end
    tick();
    total++;
    if (bus.core_start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_width: got %b want 0", bus.core_start);
    end
    wait_resp(40, cyc, ok);
    total++;
    if (!ok || cyc != 13) begin
      bad++;
      $display("FAIL single_latency: got ok=%0d cycles=%0d want 1,13", ok, cyc);
    end
    total++;
    if (bus.resp_id !== ID_W'(0) || bus.resp_data !== 128'hDEAD || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL single_resp: got id=%0d data=%h err=%b want 0 dead 0", bus.resp_id, bus.resp_data, bus.resp_err);
    end
    accept_resp();
    total++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: got rv=%b busy=%b want 0 0", bus.resp_valid, busy);
    end
    force_dead = 1'b0;
    m_rr = 0;
  endtask

  task automatic test_round_robin();
    int cyc, w; bit ok; logic [NUM_REQ-1:0] ack;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i] = {$urandom, $urandom, $urandom, $urandom};
      rk[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    drive_reqs(2'b11);
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      core_lat = $urandom_range(1, 6);
      w = pick(2'b11, m_rr);
      wait_ack(6, cyc, ack);
      total++;
      if (ack !== NUM_REQ'(1 << w)) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b want %b", n, ack, NUM_REQ'(1 << w));
      end
      tick();
      total++;
      if (bus.req_ack !== '0) begin
        bad++;
        $display("FAIL rr_ack_width%0d: got %b want 0", n, bus.req_ack);
      end
      if (n == 3) bus.req_valid = '0;
      wait_resp(20, cyc, ok);
      total++;
      if (!ok || bus.resp_id !== ID_W'(w) || bus.resp_data !== enc(rd[w], rk[w]) || bus.resp_err !== 1'b0) begin
        bad++;
        $display("FAIL rr_resp%0d: got ok=%0d id=%0d data=%h err=%b want id=%0d data=%h", n, ok, bus.resp_id, bus.resp_data, bus.resp_err, w, enc(rd[w], rk[w]));
      end
      m_rr = w;
    end
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; logic [NUM_REQ-1:0] ack; logic [127:0] exp_d;
    do_reset();
    core_lat = 5;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i] = {$urandom, $urandom, $urandom, $urandom};
      rk[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    exp_d = enc(rd[1], rk[1]);
    drive_reqs(2'b10);
    wait_ack(5, cyc, ack);
    total++;
    if (ack !== 2'b10) begin
      bad++;
      $display("FAIL bp_grant: got %b want 10", ack);
    end
    drive_reqs(2'b01);
    wait_resp(20, cyc, ok);
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== ID_W'(1) || bus.resp_data !== exp_d || bus.resp_err !== 1'b0 || bus.req_ack !== '0) begin
        bad++;
        $display("FAIL bp_hold%0d: got rv=%b id=%0d data=%h err=%b ack=%b want 1 1 %h 0 0", n, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err, bus.req_ack, exp_d);
      end
    end
    accept_resp();
    m_rr = 1;
    total++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got rv=%b busy=%b want 0 0", bus.resp_valid, busy);
    end
    tick();
    total++;
    if (bus.req_ack !== NUM_REQ'(1 << pick(2'b01, m_rr))) begin
      bad++;
      $display("FAIL bp_next_grant: got %b want 01", bus.req_ack);
    end
    bus.req_valid = '0;
    wait_resp(20, cyc, ok);
    accept_resp();
    m_rr = 0;
  endtask

  task automatic test_timeout();
    int cyc, quiet; bit ok; logic [NUM_REQ-1:0] ack;
    do_reset();
    core_lat = 80;
    rd[0] = {$urandom, $urandom, $urandom, $urandom};
    rk[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive_reqs(2'b01);
    wait_ack(5, cyc, ack);
    bus.req_valid = '0;
    tick();
    wait_resp(100, cyc, ok);
    total++;
    if (!ok || cyc != TIMEOUT) begin
      bad++;
      $display("FAIL timeout_latency: got ok=%0d cycles=%0d want 1,%0d", ok, cyc, TIMEOUT);
    end
    total++;
    if (bus.resp_err !== 1'b1 || bus.resp_data !== '0 || bus.resp_id !== ID_W'(0)) begin
      bad++;
      $display("FAIL timeout_resp: got err=%b data=%h id=%0d want 1 0 0", bus.resp_err, bus.resp_data, bus.resp_id);
    end
    accept_resp();
    m_rr = 0;
    quiet = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) quiet++;
    end
    total++;
    if (quiet != 0) begin
      bad++;
      $display("FAIL timeout_late_valid: got %0d active cycles want 0", quiet);
    end
  endtask

  task automatic test_coincidence();
    int cyc; bit ok; logic [NUM_REQ-1:0] ack;
    do_reset();
    core_lat = TIMEOUT;
    rd[0] = {$urandom, $urandom, $urandom, $urandom};
    rk[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive_reqs(2'b01);
    wait_ack(5, cyc, ack);
    bus.req_valid = '0;
    tick();
    wait_resp(100, cyc, ok);
    total++;
    if (!ok || cyc != TIMEOUT || bus.resp_err !== 1'b0 || bus.resp_data !== enc(rd[0], rk[0])) begin
      bad++;
      $display("FAIL coincidence: got ok=%0d cycles=%0d err=%b data=%h want 1 %0d 0 %h", ok, cyc, bus.resp_err, bus.resp_data, TIMEOUT, enc(rd[0], rk[0]));
    end
    accept_resp();
    m_rr = 0;
  endtask

  task automatic test_reset_in_wait();
    int cyc, quiet; bit ok; logic [NUM_REQ-1:0] ack;
    do_reset();
    core_lat = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i] = {$urandom, $urandom, $urandom, $urandom};
      rk[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    drive_reqs(2'b01);
    wait_ack(5, cyc, ack);
    bus.req_valid = '0;
    wait_resp(20, cyc, ok);
    accept_resp();
    m_rr = 0;
    core_lat = 30;
    drive_reqs(2'b10);
    wait_ack(5, cyc, ack);
    total++;
    if (ack !== NUM_REQ'(1 << pick(2'b10, m_rr))) begin
      bad++;
      $display("FAIL rst_wait_grant: got %b want 10", ack);
    end
    bus.req_valid = '0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_rr  = NUM_REQ - 1;
    total++;
    if ({bus.req_ack, bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_data, bus.core_start, bus.core_data_in, bus.core_key, busy} !== '0) begin
      bad++;
      $display("FAIL rst_wait_outputs: got ack=%b rv=%b err=%b id=%0d start=%b busy=%b din=%h want all 0", bus.req_ack, bus.resp_valid, bus.resp_err, bus.resp_id, bus.core_start, busy, bus.core_data_in);
    end
    quiet = 0;
    for (int n = 0; n < 35; n++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) quiet++;
    end
    total++;
    if (quiet != 0) begin
      bad++;
      $display("FAIL rst_wait_stale: got %0d active cycles want 0", quiet);
    end
    core_lat = 4;
    drive_reqs(2'b11);
    wait_ack(5, cyc, ack);
    total++;
    if (ack !== NUM_REQ'(1 << pick(2'b11, m_rr))) begin
      bad++;
      $display("FAIL rst_wait_regrant: got %b want 01", ack);
    end
    bus.req_valid = '0;
    wait_resp(20, cyc, ok);
    accept_resp();
    m_rr = 0;
  endtask

  task automatic test_random();
    int cyc, w, lat, exp_cyc; bit ok; bit exp_e;
    logic [NUM_REQ-1:0] ack, v; logic [127:0] exp_d;
    for (int n = 0; n < 25; n++) begin
      v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        rd[i] = {$urandom, $urandom, $urandom, $urandom};
        rk[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      lat      = $urandom_range(1, 72);
      core_lat = lat;
      w        = pick(v, m_rr);
      exp_e    = (lat > TIMEOUT);
      exp_d    = exp_e ? 128'd0 : enc(rd[w], rk[w]);
      exp_cyc  = 1 + ((lat < TIMEOUT) ? lat : TIMEOUT);
      drive_reqs(v);
      wait_ack(6, cyc, ack);
      total++;
      if (ack !== NUM_REQ'(1 << w)) begin
        bad++;
        $display("FAIL rand%0d_grant: got %b want %b (valid=%b)", n, ack, NUM_REQ'(1 << w), v);
      end
      bus.req_valid = '0;
      wait_resp(100, cyc, ok);
      total++;
      if (!ok || cyc != exp_cyc) begin
        bad++;
        $display("FAIL rand%0d_latency: got ok=%0d cycles=%0d want %0d (lat=%0d)", n, ok, cyc, exp_cyc, lat);
      end
      total++;
      if (bus.resp_id !== ID_W'(w) || bus.resp_err !== exp_e || bus.resp_data !== exp_d) begin
        bad++;
        $display("FAIL rand%0d_resp: got id=%0d err=%b data=%h want %0d %b %h", n, bus.resp_id, bus.resp_err, bus.resp_data, w, exp_e, exp_d);
      end
      repeat ($urandom_range(0, 3)) tick();
      accept_resp();
      total++;
      if (bus.resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_release: got rv=%b want 0", n, bus.resp_valid);
      end
      m_rr = w;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_coincidence();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares a single AESEncrypt core between NUM_REQ requesters using round-robin arbitration. Each accepted request's plaintext and key are latched, and the core is started with a one-cycle pulse. The block then waits for the core's valid, subject to a timeout, and returns the ciphertext to the winning requester through a response handshake. It sits between client blocks (key-schedule test harness, CBC/CTR mode wrappers) and the AES datapath.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 64, maximum cycles to wait for core_valid after start before aborting
ID_W, 3, width of resp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_data  in  NUM_REQ*128  flattened plaintexts; slice i = [i*128 +: 128]
req_key  in  NUM_REQ*256  flattened keys; slice i = [i*256 +: 256]
req_ack  out  NUM_REQ  one-hot, one-cycle pulse: request i accepted
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
resp_id  out  ID_W  index of the requester that owns the response
resp_data  out  128  ciphertext
resp_err  out  1  response produced by timeout; resp_data = 0
core_start  out  1  one-cycle start pulse to the core (drives its ready)
core_data_in  out  128  latched plaintext
core_key  out  256  latched key
core_data_out  in  128  core ciphertext
core_valid  in  1  core result valid
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; req_ack=0, resp_valid=0, resp_err=0, resp_id=0, resp_data=0.
  - core_start=0, core_data_in=0, core_key=0, busy=0.
  - rr_last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, with any req_valid bit high at the edge:
  - Winner w = first set bit scanning rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Latch req_data[w] into core_data_in and req_key[w] into core_key; latch resp_id=w.
  - Assert req_ack[w] for exactly one cycle; go to ISSUE.
- Requester contract:
  - Hold data and key stable while req_valid is high.
  - Deassert, or present a new request, on the cycle after req_ack.
  - A req_valid bit still high one cycle after its ack is treated as a new request.
- ISSUE: core_start=1 for one cycle; timeout counter cleared to 0; go to WAIT.
- WAIT: counter increments each cycle.
  - core_valid=1: resp_data<=core_data_out, resp_err<=0, resp_valid<=1; go to RESP.
  - Else, counter==TIMEOUT-1: resp_data<=0, resp_err<=1, resp_valid<=1; go to RESP.
  - core_valid and timeout in the same cycle: core_valid wins and resp_err=0.
- RESP: hold resp_valid, resp_data, resp_id and resp_err stable until resp_ready=1 at an edge. On that edge:
  - resp_valid<=0 and resp_err<=0.
  - rr_last<=resp_id.
  - Go to IDLE.
- Response latency: resp_ready may be high in the same cycle resp_valid first rises; the transfer occurs at the next edge.
- Throughput: minimum 4 cycles of overhead plus core latency per request. IDLE re-arbitrates on the edge after the RESP exit.
- core_valid is ignored outside WAIT. This covers stale results after reset or after a timeout.
- Reset mid-operation: the in-flight request is dropped without any response. The requester must reissue it.
- Only one request is in flight at a time; no queueing inside the block.
- NUM_REQ=1: arbitration degenerates to a fixed grant; behaviour is otherwise unchanged.

Test Plan:
1. Single request: req_valid=2'b01, data=128'd1, key=256'd1, core model returns 128'hDEAD after 14 cycles.
   - Expect req_ack=01 one cycle later and core_start one cycle after that.
   - Expect resp_valid with resp_id=0, resp_data=128'hDEAD, resp_err=0.
2. Round-robin: both requesters assert continuously with resp_ready=1.
   - Grant order must be 0,1,0,1.
   - Each req_ack is exactly one cycle wide and one-hot.
3. Backpressure: resp_ready held 0 for 10 cycles after resp_valid.
   - Outputs stay stable and no new req_ack occurs.
   - Raising resp_ready for one cycle gives exactly one transfer, then IDLE.
4. Timeout: core_valid never asserts, TIMEOUT=64.
   - resp_valid rises 64 cycles after core_start with resp_err=1, resp_data=0.
   - A late core_valid afterwards is ignored.
5. Coincidence: core_valid arrives exactly on the cycle the counter reaches 63 → resp_err=0 and resp_data equals the core output.
6. Reset in WAIT: assert reset for one cycle mid-encryption.
   - All outputs return to reset values and busy=0.
   - The later core_valid produces no response.
   - The next request is granted to requester 0 first.
